// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, tracks the 1-cycle cache response into IF/ID (PC at n -> ifid at n+2).
// Stall holds PC/IF-ID and parks one response in a skid entry; branch redirects/flushes; MISS_WORD halts.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_1000,
   parameter int          PC_STEP   = 8,
   parameter logic [31:0] MISS_WORD = 32'hDEAD_BEEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] PC,
   input  logic [31:0] instruction,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instruction,
   output logic        ifid_fault,
   output logic        fetch_halted
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   logic [31:0] pc_q, pc_d;
   logic        req_valid_q, req_valid_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic        skid_fault_q, skid_fault_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_fault_q, ifid_fault_d;
   logic        halted_q, halted_d;

   logic issue;
   logic resp_fault;

   assign issue      = !stall && !halted_q && !branch_taken;
   assign resp_fault = (instruction == MISS_WORD);

   always_comb begin
      pc_d         = pc_q;
      req_valid_d  = 1'b0;
      req_pc_d     = req_pc_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      skid_fault_d = skid_fault_q;
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_fault_d = ifid_fault_q;
      halted_d     = halted_q;

      if (branch_taken) begin
         // Redirect drops the in-flight response and anything parked in skid.
         pc_d         = branch_target & ~32'h7;
         skid_valid_d = 1'b0;
         ifid_valid_d = 1'b0;
         ifid_fault_d = 1'b0;
         halted_d     = 1'b0;
      end else begin
         if (issue) begin
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
            pc_d        = pc_q + STEP;
         end
         if (req_valid_q) begin
            if (resp_fault) begin
               halted_d = 1'b1;
            end
            if (!stall) begin
               ifid_valid_d = 1'b1;
               ifid_pc_d    = req_pc_q;
               ifid_instr_d = instruction;
               ifid_fault_d = resp_fault;
            end else begin
               skid_valid_d = 1'b1;
               skid_pc_d    = req_pc_q;
               skid_instr_d = instruction;
               skid_fault_d = resp_fault;
            end
         end else if (!stall) begin
            // Stall never lets a response and a full skid coincide, so draining here is safe.
            ifid_valid_d = skid_valid_q;
            if (skid_valid_q) begin
               ifid_pc_d    = skid_pc_q;
               ifid_instr_d = skid_instr_q;
               ifid_fault_d = skid_fault_q;
               skid_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         req_valid_q  <= 1'b0;
         req_pc_q     <= 32'h0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= 32'h0;
         skid_instr_q <= 32'h0;
         skid_fault_q <= 1'b0;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= 32'h0;
         ifid_instr_q <= 32'h0;
         ifid_fault_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         req_valid_q  <= req_valid_d;
         req_pc_q     <= req_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_fault_q <= skid_fault_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_fault_q <= ifid_fault_d;
         halted_q     <= halted_d;
      end
   end

   assign PC               = pc_q;
   assign ifid_valid       = ifid_valid_q;
   assign ifid_pc          = ifid_pc_q;
   assign ifid_instruction = ifid_instr_q;
   assign ifid_fault       = ifid_fault_q;
   assign fetch_halted     = halted_q;

endmodule
